// File: rtl/fm_gen_test.sv
// fm_gen_test: mono FM broadcast DDS transmitter with a 57 kHz differential-biphase RDS subcarrier
module fm_gen_test #(
  parameter int unsigned C_CLK_HZ     = 240000000,
  parameter int unsigned C_HZ2FW      = 32'(((64'd1 << 56) + 64'(C_CLK_HZ) / 2) / 64'(C_CLK_HZ)),
  parameter int          C_AUDIO_GAIN = int'((64'd75000 * 64'd33554432 + 64'(C_CLK_HZ) / 2) / 64'(C_CLK_HZ)),
  parameter int          C_RDS_GAIN   = int'((64'd2000 * 64'd4294967296 + 64'(C_CLK_HZ) * 64'd127 / 2) / (64'(C_CLK_HZ) * 64'd127)),
  parameter int          C_RDS_LEN    = 52,
  parameter logic [31:0] C_SC_STEP    = 32'((64'd57000 * 64'd4294967296 + 64'(C_CLK_HZ) / 2) / 64'(C_CLK_HZ))
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] pcm_in_left,
  input  logic signed [15:0] pcm_in_right,
  input  logic        [31:0] cw_freq,
  output logic        [5:0]  rds_addr,
  input  logic        [7:0]  rds_data,
  output logic               fm_antenna
);
  typedef enum logic {PRELOAD, RUN} state_t;
  localparam logic signed [7:0] SINE [16] = '{8'sd0, 8'sd49, 8'sd90, 8'sd117, 8'sd127, 8'sd117, 8'sd90, 8'sd49,
                                             8'sd0, -8'sd49, -8'sd90, -8'sd117, -8'sd127, -8'sd117, -8'sd90, -8'sd49};
  localparam logic signed [31:0] AG = 32'(C_AUDIO_GAIN);
  localparam logic signed [31:0] RG = 32'(C_RDS_GAIN);
  state_t state, state_nx;
  logic signed [15:0] left_r, right_r;
  logic signed [16:0] mono;
  logic signed [31:0] audio_fw, rds_fw;
  logic signed [7:0]  sine, sp;
  logic [63:0] base_prod;
  logic [31:0] cw_r, base_fw, inc, acc, sc_acc, sc_nx;
  logic [7:0]  sr;
  logic [4:0]  cyc;
  logic [2:0]  bit_cnt;
  logic sc_wrap, pre_cnt, run, load_pre, e_q, e, half, sub_end, bit_end, byte_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= PRELOAD;
    else state <= state_nx;
  always_comb state_nx = (state == PRELOAD && pre_cnt) ? RUN : state;
  always_comb begin
    run      = state == RUN;
    load_pre = state == PRELOAD && pre_cnt;
  end
  // e is the differentially encoded value of the bit currently on air
  always_comb begin
    base_prod    = 64'(cw_r) * 64'(C_HZ2FW);
    mono         = (17'(left_r) + 17'(right_r)) >>> 1;
    {sc_wrap, sc_nx} = {1'b0, sc_acc} + {1'b0, C_SC_STEP};
    sine         = SINE[sc_acc[31:28]];
    e            = sr[7] ^ e_q;
    sp           = (e ^ half) ? -sine : sine;
    sub_end      = run && sc_wrap && cyc == 5'd23;
    bit_end      = sub_end && half;
    byte_end     = bit_end && bit_cnt == 3'd7;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      left_r     <= '0;
      right_r    <= '0;
      cw_r       <= '0;
      base_fw    <= '0;
      audio_fw   <= '0;
      rds_fw     <= '0;
      inc        <= '0;
      acc        <= '0;
      sc_acc     <= '0;
      fm_antenna <= 1'b0;
    end else begin
      left_r     <= pcm_in_left;
      right_r    <= pcm_in_right;
      cw_r       <= cw_freq;
      base_fw    <= 32'(base_prod >> 24);
      audio_fw   <= (32'(mono) * AG) >>> 8;
      rds_fw     <= 32'(sp) * RG;
      inc        <= base_fw + audio_fw + rds_fw;
      acc        <= acc + inc;
      sc_acc     <= sc_nx;
      fm_antenna <= acc[31];
    end
  // a byte load replaces the shift on the last bit, so the new byte's MSB starts in its first half
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_cnt  <= 1'b0;
      cyc      <= '0;
      half     <= 1'b0;
      bit_cnt  <= '0;
      e_q      <= 1'b0;
      sr       <= '0;
      rds_addr <= '0;
    end else begin
      pre_cnt <= 1'b1;
      if (run && sc_wrap) cyc <= (cyc == 5'd23) ? 5'd0 : cyc + 5'd1;
      if (sub_end) half <= !half;
      if (bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
        e_q     <= e;
      end
      if (load_pre || byte_end) begin
        sr       <= rds_data;
        rds_addr <= (rds_addr == 6'(C_RDS_LEN - 1)) ? 6'd0 : rds_addr + 6'd1;
      end else if (bit_end) sr <= {sr[6:0], 1'b0};
    end
endmodule

// File: tb/tb_fm_gen_test.sv
// tb_fm_gen_test: scoreboard bench for fm_gen_test with a fast RDS subcarrier (4 clocks per cycle) and an 8-byte message
module tb_fm_gen_test;
  localparam int LEN = 8;
  localparam logic [31:0] STEP = 32'h4000_0000;
  localparam logic [63:0] HZ2FW = 64'd300239975;
  typedef struct {int due; int kind; logic [31:0] exp;} sb_t;
  logic clk = 1'b0, rst_n = 1'b1, fm_antenna;
  logic signed [15:0] pcm_in_left = '0, pcm_in_right = '0;
  logic [31:0] cw_freq = '0, base1, base2;
  logic [5:0] rds_addr;
  logic [7:0] rds_data;
  logic [7:0] mem [LEN];
  int total = 0, bad = 0, cyc = 0;
  sb_t sb[$];
  fm_gen_test #(.C_RDS_LEN(LEN), .C_SC_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .pcm_in_left(pcm_in_left), .pcm_in_right(pcm_in_right),
    .cw_freq(cw_freq), .rds_addr(rds_addr), .rds_data(rds_data), .fm_antenna(fm_antenna)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rds_data <= mem[rds_addr[2:0]];
  always @(posedge clk or negedge rst_n) cyc <= !rst_n ? 0 : cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d (0x%h) want=%0d (0x%h)", tag, cyc, $signed(obs), obs, $signed(exp), exp);
    end
  endtask
  function automatic void push(input int due, input int kind, input logic [31:0] exp);
    sb_t t;
    int i = sb.size();
    t.due = due;
    t.kind = kind;
    t.exp = exp;
    while (i > 0 && sb[i-1].due > due) i--;
    sb.insert(i, t);
  endfunction
  function automatic logic exp_e(input int b);
    logic e = 1'b0;
    for (int i = 0; i <= b; i++) e ^= mem[(i / 8) % LEN][7 - i % 8];
    return e;
  endfunction
  // expected rds_fw after clock edge n: state of edge n-1 drives sine phase, bit and half
  function automatic logic [31:0] rds_exp(input int n);
    int m = n - 1;
    int w = m / 4;
    int s = (m % 4 == 1) ? 127 : (m % 4 == 3) ? -127 : 0;
    if (exp_e(w / 48) ^ ((w / 24) % 2 == 1)) s = -s;
    return 32'(s * 282);
  endfunction
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    sb_t t;
    while (rst_n && sb.size() > 0 && sb[0].due == cyc) begin
      t = sb.pop_front();
      case (t.kind)
        0: check("base_fw", dut.base_fw, t.exp);
        1: check("audio_fw", dut.audio_fw, t.exp);
        2: check("inc", dut.inc, t.exp);
        3: check("rds_fw", dut.rds_fw, t.exp);
        4: check("rds_addr", 32'(rds_addr), t.exp);
        default: check("e", 32'(dut.e), t.exp);
      endcase
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int rises, diff;
    logic prev;
    for (int i = 0; i < LEN; i++) mem[i] = 8'(i);
    cw_freq = 32'd100000000;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(rds_addr), 0);
    check("rst_ant", 32'(fm_antenna), 0);
    check("rst_acc", dut.acc, 0);
    rst_n = 1'b1;
    push(1, 4, 0);
    push(2, 4, 1);
    for (int k = 1; k <= 9; k++) begin
      push(1536 * k - 1, 4, 32'(k % LEN));
      push(1536 * k, 4, 32'((k + 1) % LEN));
    end
    for (int n = 3; n <= 13900; n++) push(n, 3, rds_exp(n));
    base1 = 32'((64'd100000000 * HZ2FW) >> 24);
    base2 = 32'((64'd60000000 * HZ2FW) >> 24);
    push(20, 0, base1);
    push(20, 1, 0);
    wait_cyc(20);
    diff = int'(dut.base_fw) - 1789569707;
    check("base_vs_ideal", 32'(diff >= -8 && diff <= 8), 1);
    wait_cyc(30);
    pcm_in_left = 16'sd16384;
    pcm_in_right = 16'sd16384;
    push(31, 1, 0);
    push(32, 1, 671104);
    push(32, 2, base1 + rds_exp(31));
    push(33, 2, base1 + 32'd671104 + rds_exp(32));
    wait_cyc(40);
    pcm_in_left = 16'sd32767;
    pcm_in_right = -16'sd32768;
    push(41, 1, 671104);
    push(42, 1, -32'sd41);
    push(43, 2, base1 - 32'd41 + rds_exp(42));
    wait_cyc(50);
    cw_freq = 32'd60000000;
    push(51, 0, base1);
    push(52, 0, base2);
    push(53, 2, base2 - 32'd41 + rds_exp(52));
    wait_cyc(60);
    cw_freq = 32'd100000000;
    pcm_in_left = '0;
    pcm_in_right = '0;
    wait_cyc(100);
    rises = 0;
    prev = fm_antenna;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (fm_antenna && !prev) rises++;
      prev = fm_antenna;
    end
    check("ant_rises_in_1000pm1", 32'(rises >= 999 && rises <= 1001), 1);
    wait_cyc(13950);
    check("sb_drain_a", sb.size(), 0);
    check("pre_rst_addr", 32'(rds_addr), 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(rds_addr), 0);
    check("mid_rst_ant", 32'(fm_antenna), 0);
    check("mid_rst_acc", dut.acc, 0);
    check("mid_rst_inc", dut.inc, 0);
    check("mid_rst_e", 32'(dut.e), 0);
    for (int i = 0; i < LEN; i++) mem[i] = 8'h80;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(1, 4, 0);
    push(2, 4, 1);
    push(1535, 4, 1);
    push(1536, 4, 2);
    for (int b = 0; b <= 8; b++) push(b * 192 + 50, 5, 32'(exp_e(b)));
    for (int n = 3; n <= 3200; n++) push(n, 3, rds_exp(n));
    wait_cyc(3250);
    check("sb_drain_b", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
